matrix_decoder: RTL and testbench

Downstream of the coordinator: deserializes the byte stream that follows an "M" command into a 2×2 complex matrix of 37-bit signed fixed-point entries. The coordinator pulses `start` on the command byte, then forwards each payload byte with a one-cycle valid. After 40 bytes the block presents the whole matrix in a held register and pulses `matrix_valid` for the downstream compiler datapath.

---
 rtl/qc_pkg.sv | 16 +
 rtl/byte_assembler.sv | 41 ++++
 rtl/matrix_decoder.sv | 91 +++++++++
 tb/tb_matrix_decoder.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/qc_pkg.sv
// Shared quantum-compiler types: fixed-point entry format and matrix decoder states.
// Imported by the coordinator, the matrix decoder and the downstream compiler.
package qc_pkg;

   localparam int ENTRY_W         = 37;
   localparam int BYTES_PER_ENTRY = 5;
   localparam int NUM_ENTRIES     = 8;

   typedef logic signed [ENTRY_W-1:0] entry_t;

   typedef enum logic [0:0] {
      MTX_IDLE    = 1'b0,
      MTX_COLLECT = 1'b1
   } mtx_state_e;

endpackage

// File: rtl/byte_assembler.sv
// LSB-first byte assembler: holds the first BYTES_PER_ENTRY-1 bytes of a component
// and presents the full component combinationally alongside the final byte.
module byte_assembler #(
   parameter int ENTRY_W         = 37,
   parameter int BYTES_PER_ENTRY = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clear,
   input  logic               shift_en,
   input  logic [7:0]         byte_in,
   output logic [ENTRY_W-1:0] word,
   output logic               word_done
);

   localparam int HOLD_W = 8 * (BYTES_PER_ENTRY - 1);
   localparam int CNT_W  = $clog2(BYTES_PER_ENTRY);
   localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES_PER_ENTRY - 1);

   logic [HOLD_W-1:0] hold;
   logic [CNT_W-1:0]  byte_cnt;

   // The last byte is not stored: it is merged on the fly so the component
   // is usable on the same edge that accepts it. Its top bits beyond ENTRY_W drop here.
   assign word_done = shift_en && (byte_cnt == LAST_BYTE);
   assign word      = {byte_in[ENTRY_W-HOLD_W-1:0], hold};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold     <= '0;
         byte_cnt <= '0;
      end else if (clear) begin
         hold     <= '0;
         byte_cnt <= '0;
      end else if (shift_en) begin
         hold     <= {byte_in, hold[HOLD_W-1:8]};
         byte_cnt <= word_done ? '0 : byte_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/matrix_decoder.sv
// Deserializes the 40-byte "M" payload into a 2x2 complex matrix of signed
// fixed-point components and presents it in a held register with a one-cycle valid.
module matrix_decoder #(
   parameter int ENTRY_W         = qc_pkg::ENTRY_W,
   parameter int BYTES_PER_ENTRY = qc_pkg::BYTES_PER_ENTRY,
   parameter int NUM_ENTRIES     = qc_pkg::NUM_ENTRIES
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           start,
   input  logic [7:0]                     byte_in,
   input  logic                           byte_valid,
   output logic                           busy,
   output logic [NUM_ENTRIES*ENTRY_W-1:0] matrix_out,
   output logic                           matrix_valid
);

   localparam int IDX_W = $clog2(NUM_ENTRIES);
   localparam logic [IDX_W-1:0] LAST_ENTRY = IDX_W'(NUM_ENTRIES - 1);

   qc_pkg::mtx_state_e state;
   logic [IDX_W-1:0]   entry_idx;
   logic               shift_en;
   logic               word_done;
   logic               last_word;
   qc_pkg::entry_t     word;
   qc_pkg::entry_t     staging [NUM_ENTRIES-1];
   logic [NUM_ENTRIES*ENTRY_W-1:0] next_matrix;

   // start always wins over a coincident strobe, so the byte is dropped.
   assign shift_en  = byte_valid && (state == qc_pkg::MTX_COLLECT) && !start;
   assign last_word = word_done && (entry_idx == LAST_ENTRY);
   assign busy      = (state == qc_pkg::MTX_COLLECT);

   byte_assembler #(
      .ENTRY_W         (ENTRY_W),
      .BYTES_PER_ENTRY (BYTES_PER_ENTRY)
   ) u_byte_assembler (
      .clk       (clk),
      .reset     (reset),
      .clear     (start),
      .shift_en  (shift_en),
      .byte_in   (byte_in),
      .word      (word),
      .word_done (word_done)
   );

   // NOTE: staging is deliberately not reset; every slot is rewritten before
   // the array is ever copied out, so a reset would only add fan-out.
   always_ff @(posedge clk) begin
      if (word_done && !last_word) begin
         staging[entry_idx] <= word;
      end
   end

   // The final component bypasses staging so the copy happens on its own edge.
   always_comb begin
      // NOTE: default first so no path through this block can infer a latch.
      next_matrix = '0;
      for (int i = 0; i < NUM_ENTRIES - 1; i++) begin
         next_matrix[i*ENTRY_W +: ENTRY_W] = staging[i];
      end
      next_matrix[(NUM_ENTRIES-1)*ENTRY_W +: ENTRY_W] = word;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= qc_pkg::MTX_IDLE;
         entry_idx    <= '0;
         matrix_out   <= '0;
         matrix_valid <= 1'b0;
      end else begin
         // NOTE: non-blocking throughout so every register samples pre-edge values.
         matrix_valid <= 1'b0;
         if (start) begin
            state     <= qc_pkg::MTX_COLLECT;
            entry_idx <= '0;
         end else if (word_done) begin
            if (last_word) begin
               state        <= qc_pkg::MTX_IDLE;
               entry_idx    <= '0;
               matrix_out   <= next_matrix;
               matrix_valid <= 1'b1;
            end else begin
               entry_idx <= entry_idx + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_matrix_decoder.sv
// Directed bench for matrix_decoder: idle filtering, gapped and back-to-back
// transfers, abort/restart, upper-bit discard and asynchronous reset mid-transfer.
module tb_matrix_decoder;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [7:0]   byte_in;
   logic         byte_valid;
   logic         busy;
   logic [295:0] matrix_out;
   logic         matrix_valid;

   int compared   = 0;
   int mismatched = 0;
   int pulses     = 0;
   int p0;

   logic [7:0]   mat_a [40];
   logic [7:0]   vec   [40];
   logic [295:0] exp_a;
   logic [295:0] exp_11;
   logic [295:0] exp_ff;

   matrix_decoder dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .byte_in      (byte_in),
      .byte_valid   (byte_valid),
      .busy         (busy),
      .matrix_out   (matrix_out),
      .matrix_valid (matrix_valid)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (matrix_valid) pulses++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [295:0] obs, input logic [295:0] expv);
      compared++;
      assert (obs === expv) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      byte_in    = b;
      byte_valid = 1'b1;
      tick();
      byte_valid = 1'b0;
      repeat (gap) tick();
   endtask

   task automatic send_vec(input int first, input int n, input int gap);
      for (int k = first; k < first + n; k++) send_byte(vec[k], gap);
   endtask

   function automatic logic [36:0] comp(input int i);
      return matrix_out[i*37 +: 37];
   endfunction

   initial begin
      mat_a = '{8'hA0, 8'h99, 8'h27, 8'hA8, 8'h05,  8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                8'hA1, 8'h99, 8'h27, 8'hA8, 8'h05,  8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                8'hA2, 8'h99, 8'h27, 8'hA8, 8'h05,  8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                8'h5D, 8'h66, 8'hD8, 8'h57, 8'h1A,  8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      exp_a = '0;
      exp_a[0*37 +: 37] = 37'h05A82799A0;
      exp_a[2*37 +: 37] = 37'h05A82799A1;
      exp_a[4*37 +: 37] = 37'h05A82799A2;
      exp_a[6*37 +: 37] = 37'h1A57D8665D;
      exp_11 = '0;
      exp_ff = '0;
      for (int i = 0; i < 8; i++) begin
         exp_11[i*37 +: 37] = 37'h1111111111;
         exp_ff[i*37 +: 37] = 37'h1F00000000;
      end

      // Reset state
      reset = 1'b1; start = 1'b0; byte_in = 8'h00; byte_valid = 1'b0;
      #2;
      check("reset_matrix_out", matrix_out, '0);
      check("reset_busy", 296'(busy), 296'(1'b0));
      check("reset_valid", 296'(matrix_valid), 296'(1'b0));
      repeat (2) tick();
      reset = 1'b0;
      tick();

      // Strobes without start are ignored
      for (int k = 0; k < 45; k++) send_byte(8'hFF, 0);
      check("idle_busy", 296'(busy), 296'(1'b0));
      check("idle_matrix_out", matrix_out, '0);
      check("idle_pulses", 296'(pulses), 296'(0));

      // Full matrix, one idle cycle between bytes
      vec = mat_a;
      p0 = pulses;
      pulse_start();
      check("gap_busy_after_start", 296'(busy), 296'(1'b1));
      send_vec(0, 40, 1);
      check("gap_pulses", 296'(pulses - p0), 296'(1));
      check("gap_comp0", 296'(comp(0)), 296'(37'h05A82799A0));
      check("gap_comp6", 296'(comp(6)), 296'(37'h1A57D8665D));
      check("gap_comp6_signed", 296'($signed(comp(6)) == -37'sd24296004003), 296'(1'b1));
      check("gap_comp1", 296'(comp(1)), 296'(0));
      check("gap_matrix", matrix_out, exp_a);
      check("gap_busy_done", 296'(busy), 296'(1'b0));

      // Back-to-back strobes with exact latency
      p0 = pulses;
      pulse_start();
      send_vec(0, 39, 0);
      check("b2b_valid_before_last", 296'(matrix_valid), 296'(1'b0));
      check("b2b_busy_before_last", 296'(busy), 296'(1'b1));
      send_vec(39, 1, 0);
      check("b2b_valid_after_last", 296'(matrix_valid), 296'(1'b1));
      check("b2b_busy_after_last", 296'(busy), 296'(1'b0));
      check("b2b_matrix", matrix_out, exp_a);
      tick();
      check("b2b_valid_one_cycle", 296'(matrix_valid), 296'(1'b0));
      check("b2b_pulses", 296'(pulses - p0), 296'(1));

      // Abort after 17 bytes, restart with start and a coincident dropped byte
      p0 = pulses;
      pulse_start();
      send_vec(0, 17, 0);
      check("abort_partial_held", matrix_out, exp_a);
      start = 1'b1; byte_valid = 1'b1; byte_in = 8'hEE;
      tick();
      start = 1'b0; byte_valid = 1'b0;
      check("abort_busy_restart", 296'(busy), 296'(1'b1));
      for (int k = 0; k < 40; k++) vec[k] = 8'h11;
      send_vec(0, 40, 0);
      tick();
      for (int i = 0; i < 8; i++) check($sformatf("abort_comp%0d", i), 296'(comp(i)), 296'(37'h1111111111));
      check("abort_matrix", matrix_out, exp_11);
      check("abort_pulses", 296'(pulses - p0), 296'(1));

      // Fifth byte 0xFF: upper bits discarded, no stall
      for (int k = 0; k < 40; k++) vec[k] = (k % 5 == 4) ? 8'hFF : 8'h00;
      p0 = pulses;
      pulse_start();
      send_vec(0, 40, 2);
      check("upper_comp0", 296'(comp(0)), 296'(37'h1F00000000));
      check("upper_comp0_top", 296'(matrix_out[36:32]), 296'(5'h1F));
      check("upper_matrix", matrix_out, exp_ff);
      check("upper_busy", 296'(busy), 296'(1'b0));
      check("upper_pulses", 296'(pulses - p0), 296'(1));

      // Asynchronous reset after 25 bytes clears a held matrix immediately
      vec = mat_a;
      pulse_start();
      send_vec(0, 25, 0);
      #2;
      reset = 1'b1;
      #1;
      check("rst_matrix_out", matrix_out, '0);
      check("rst_busy", 296'(busy), 296'(1'b0));
      check("rst_valid", 296'(matrix_valid), 296'(1'b0));
      #1;
      reset = 1'b0;
      tick();
      p0 = pulses;
      pulse_start();
      send_vec(0, 40, 0);
      check("post_rst_valid", 296'(matrix_valid), 296'(1'b1));
      check("post_rst_matrix", matrix_out, exp_a);
      tick();
      check("post_rst_pulses", 296'(pulses - p0), 296'(1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
